// File: rtl/l1602a_pkg.sv
// Shared constants for the 1602A bus receiver: timing defaults, interface
// states and the opcode masks used to track function-set / clear / home.
package l1602a_pkg;

    localparam int T_EPW_DEF   = 6;
    localparam int T_EXEC_DEF  = 1008;
    localparam int T_CLEAR_DEF = 39360;

    typedef enum logic [1:0] {
        IF8    = 2'd0,
        IF4_HI = 2'd1,
        IF4_LO = 2'd2
    } if_state_t;

    localparam logic [7:0] FUNCSET_MASK = 8'hE0;
    localparam logic [7:0] FUNCSET      = 8'h20;
    localparam int         DL_BIT       = 4;
    localparam logic [7:0] CLEAR        = 8'h01;
    localparam logic [7:0] HOME_MASK    = 8'hFE;
    localparam logic [7:0] HOME         = 8'h02;

    function automatic logic is_funcset(input logic rs, input logic [7:0] b);
        return !rs && ((b & FUNCSET_MASK) == FUNCSET);
    endfunction

    // Clear and return-home take the long execution window.
    function automatic logic is_long_op(input logic rs, input logic [7:0] b);
        return !rs && (b == CLEAR || (b & HOME_MASK) == HOME);
    endfunction

endpackage

// File: rtl/l1602a_edge_sync.sv
// Synchronizes the LCD pins, detects the E falling edge and presents the
// RS/RW/data sample taken the cycle before the fall.
module l1602a_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int DW          = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    ctrl,
    input  logic [DW-1:0] data,
    output logic          e,
    output logic          fall,
    output logic          rs,
    output logic          rw,
    output logic [DW-1:0] nib
);
    localparam int W = DW + 3;

    logic [SYNC_STAGES-1:0][W-1:0] stage;
    logic [W-1:0]                  prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage <= '0;
            prev  <= '0;
        end else begin
            stage[0] <= {ctrl, data};
            for (int i = 1; i < SYNC_STAGES; i++)
                stage[i] <= stage[i-1];
            prev <= stage[SYNC_STAGES-1];
        end
    end

    // Packing is {RS, RW, E, data}.
    assign e    = stage[SYNC_STAGES-1][DW];
    assign fall = !e && prev[DW];
    assign rs   = prev[DW+2];
    assign rw   = prev[DW+1];
    assign nib  = prev[DW-1:0];

endmodule

// File: rtl/l1602a_bus_receiver.sv
// LCD-side receiver: rebuilds bytes from E strobes, tracks 8/4-bit mode,
// emulates the busy window and flags pulse-width, busy and pairing errors.
module l1602a_bus_receiver
    import l1602a_pkg::*;
#(
    parameter int MODE         = 1,
    parameter int SYNC_STAGES  = 2,
    parameter int COUNT_SIZE   = 20,
    parameter int T_EPW_CLKS   = T_EPW_DEF,
    parameter int T_EXEC_CLKS  = T_EXEC_DEF,
    parameter int T_CLEAR_CLKS = T_CLEAR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         lcd_ctrl,
    input  logic [7-4*MODE:0]  lcd_data,
    output logic               rx_valid,
    output logic               rx_rs,
    output logic [7:0]         rx_byte,
    output logic               busy,
    output logic               if_4bit,
    output logic               err_pw,
    output logic               err_busy,
    output logic               err_seq
);
    localparam int DW = 8 - 4 * MODE;

    logic          s_e, fall, s_rs, s_rw;
    logic [DW-1:0] s_nib;
    logic [7:0]    pins;

    l1602a_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .DW(DW)) u_sync (
        .clk (clk),
        .rst (rst),
        .ctrl(lcd_ctrl),
        .data(lcd_data),
        .e   (s_e),
        .fall(fall),
        .rs  (s_rs),
        .rw  (s_rw),
        .nib (s_nib)
    );

    // Left-justified so 4-pin mode sees D7..D4 in pins[7:4].
    assign pins = 8'(s_nib) << (8 - DW);

    if_state_t             state, next_state;
    logic [COUNT_SIZE-1:0] width_cnt, busy_cnt;
    logic [3:0]            hi_nib;
    logic                  hi_rs, hi_rw;
    logic                  emit, seq_bad;
    logic [7:0]            emit_byte;

    always_comb begin
        emit       = 1'b0;
        seq_bad    = 1'b0;
        emit_byte  = pins;
        next_state = state;
        if (fall) begin
            if (MODE == 0) begin
                emit = !s_rw;
            end else begin
                case (state)
                    IF8: begin
                        emit = !s_rw;
                        if (!s_rw && is_funcset(s_rs, pins) && !pins[DL_BIT])
                            next_state = IF4_HI;
                    end
                    IF4_HI: next_state = IF4_LO;
                    IF4_LO: begin
                        next_state = IF4_HI;
                        emit_byte  = {hi_nib, pins[7:4]};
                        if (s_rs != hi_rs || s_rw != hi_rw) begin
                            seq_bad = 1'b1;
                        end else if (!s_rw) begin
                            emit = 1'b1;
                            if (is_funcset(s_rs, emit_byte) && emit_byte[DL_BIT])
                                next_state = IF8;
                        end
                    end
                    default: next_state = IF8;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IF8;
            width_cnt <= '0;
            busy_cnt  <= '0;
            hi_nib    <= '0;
            hi_rs     <= 1'b0;
            hi_rw     <= 1'b0;
            rx_valid  <= 1'b0;
            rx_rs     <= 1'b0;
            rx_byte   <= '0;
            err_pw    <= 1'b0;
            err_busy  <= 1'b0;
            err_seq   <= 1'b0;
        end else begin
            state <= next_state;

            if (!s_e)
                width_cnt <= '0;
            else if (width_cnt != '1)
                width_cnt <= width_cnt + 1'b1;

            if (fall && state == IF4_HI) begin
                hi_nib <= pins[7:4];
                hi_rs  <= s_rs;
                hi_rw  <= s_rw;
            end

            rx_valid <= emit;
            if (emit) begin
                rx_byte <= emit_byte;
                rx_rs   <= s_rs;
            end

            err_pw   <= fall && (width_cnt < COUNT_SIZE'(T_EPW_CLKS));
            err_busy <= fall && !s_rw && (busy_cnt != '0);
            err_seq  <= seq_bad;

            if (emit)
                busy_cnt <= is_long_op(s_rs, emit_byte) ? COUNT_SIZE'(T_CLEAR_CLKS)
                                                        : COUNT_SIZE'(T_EXEC_CLKS);
            else if (busy_cnt != '0)
                busy_cnt <= busy_cnt - 1'b1;
        end
    end

    assign busy    = (busy_cnt != '0);
    assign if_4bit = (state != IF8);

endmodule
